// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV32M multiply pipeline and iterative divider sharing one tagged result port
`timescale 1ns/1ps

// Multiplies complete in MUL_STAGES cycles without stalling. Divides run a
// restoring iteration on operand magnitudes and fix up signs on the last
// step. Both feed a single registered result broadcast, with the multiply
// pipeline exit taking priority over a finished divide.
module muldiv_unit #(
  parameter int ROB_WIDTH  = 4,
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_signal,
  input  logic                 cal_signal,
  input  logic [2:0]           opcode,
  input  logic [XLEN-1:0]      lhs,
  input  logic [XLEN-1:0]      rhs,
  input  logic [ROB_WIDTH-1:0] tag,
  output logic                 div_busy,
  output logic                 done_result,
  output logic [XLEN-1:0]      value_result,
  output logic [ROB_WIDTH-1:0] tag_result
);

  localparam int CW    = $clog2(XLEN) + 1;
  localparam int NPIPE = (MUL_STAGES > 1) ? (MUL_STAGES - 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // ---------------------------------------------------------------------
  // Issue qualification
  // ---------------------------------------------------------------------
  logic issue_ok;
  logic mul_issue;
  logic div_issue;

  assign issue_ok  = rdy_in & cal_signal & ~clear_signal;
  assign mul_issue = issue_ok & ~opcode[2];
  assign div_issue = issue_ok & opcode[2] & ~div_busy;

  // ---------------------------------------------------------------------
  // Multiply: full-width product, result half selected at issue
  // ---------------------------------------------------------------------
  logic                 mul_a_signed;
  logic                 mul_b_signed;
  logic [2*XLEN-1:0]    mul_a;
  logic [2*XLEN-1:0]    mul_b;
  logic [2*XLEN-1:0]    mul_prod;
  logic [XLEN-1:0]      mul_word;

  logic                 mul_exit_v;
  logic [XLEN-1:0]      mul_exit_val;
  logic [ROB_WIDTH-1:0] mul_exit_tag;

  // Sign-extend operands per opcode so one 2*XLEN multiply covers all four forms
  always_comb begin
    mul_a_signed = (opcode[1:0] == 2'b01) | (opcode[1:0] == 2'b10);
    mul_b_signed = (opcode[1:0] == 2'b01);
    mul_a        = {{XLEN{mul_a_signed & lhs[XLEN-1]}}, lhs};
    mul_b        = {{XLEN{mul_b_signed & rhs[XLEN-1]}}, rhs};
    mul_prod     = mul_a * mul_b;
    mul_word     = (opcode[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
  end

  generate
    if (MUL_STAGES == 1) begin : g_mul_direct
      assign mul_exit_v   = mul_issue;
      assign mul_exit_val = mul_word;
      assign mul_exit_tag = tag;
    end else begin : g_mul_pipe
      logic [NPIPE-1:0]     pv_q;
      logic [XLEN-1:0]      pval_q [NPIPE];
      logic [ROB_WIDTH-1:0] ptag_q [NPIPE];

      // Stage valids: shift each enabled cycle, dropped entirely on flush
      always_ff @(posedge clk_in) begin
        if (!rst_in) begin
          pv_q <= '0;
        end else if (rdy_in) begin
          if (clear_signal) begin
            pv_q <= '0;
          end else begin
            pv_q[0] <= mul_issue;
            for (int i = 1; i < NPIPE; i++) begin
              pv_q[i] <= pv_q[i-1];
            end
          end
        end
      end

      // Stage payloads: only meaningful where the matching valid is set
      always_ff @(posedge clk_in) begin
        if (rdy_in) begin
          pval_q[0] <= mul_word;
          ptag_q[0] <= tag;
          for (int i = 1; i < NPIPE; i++) begin
            pval_q[i] <= pval_q[i-1];
            ptag_q[i] <= ptag_q[i-1];
          end
        end
      end

      assign mul_exit_v   = pv_q[NPIPE-1];
      assign mul_exit_val = pval_q[NPIPE-1];
      assign mul_exit_tag = ptag_q[NPIPE-1];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------
  div_state_t           state_q;
  div_state_t           state_d;

  logic [XLEN-1:0]      rem_q;
  logic [XLEN-1:0]      quo_q;
  logic [XLEN-1:0]      dvs_q;
  logic [CW-1:0]        cnt_q;
  logic                 neg_quo_q;
  logic                 neg_rem_q;
  logic                 want_rem_q;
  logic [XLEN-1:0]      dres_q;
  logic [ROB_WIDTH-1:0] dtag_q;

  logic                 div_out;
  logic                 last_iter;

  logic                 d_signed;
  logic                 lhs_neg;
  logic                 rhs_neg;
  logic [XLEN-1:0]      lhs_mag;
  logic [XLEN-1:0]      rhs_mag;
  logic                 div_by_zero;
  logic                 div_overflow;
  logic                 div_special;
  logic [XLEN-1:0]      special_res;

  logic [XLEN:0]        shifted;
  logic [XLEN:0]        diff;
  logic                 take;
  logic [XLEN-1:0]      rem_nx;
  logic [XLEN-1:0]      quo_nx;
  logic [XLEN-1:0]      quo_fix;
  logic [XLEN-1:0]      rem_fix;

  // Operand magnitudes and the two cases that bypass iteration
  always_comb begin
    d_signed     = ~opcode[0];
    lhs_neg      = d_signed & lhs[XLEN-1];
    rhs_neg      = d_signed & rhs[XLEN-1];
    lhs_mag      = lhs_neg ? (~lhs + 1'b1) : lhs;
    rhs_mag      = rhs_neg ? (~rhs + 1'b1) : rhs;
    div_by_zero  = (rhs == '0);
    div_overflow = d_signed & (lhs == {1'b1, {(XLEN-1){1'b0}}}) & (&rhs);
    div_special  = div_by_zero | div_overflow;
    if (opcode[1]) begin
      special_res = div_by_zero ? lhs : '0;
    end else begin
      special_res = div_by_zero ? '1 : lhs;
    end
  end

  // One restoring step: shift in next dividend bit, subtract if it fits
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    take    = ~diff[XLEN];
    rem_nx  = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_nx  = {quo_q[XLEN-2:0], take};
    quo_fix = neg_quo_q ? (~quo_nx + 1'b1) : quo_nx;
    rem_fix = neg_rem_q ? (~rem_nx + 1'b1) : rem_nx;
  end

  // Divider state register; holds while paused
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  // Divider next state: flush wins, a waiting result yields to a mul exit
  always_comb begin
    state_d = state_q;
    if (clear_signal) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_issue) begin
            state_d = div_special ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (last_iter) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (!mul_exit_v) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Divider outputs decoded from the current state
  always_comb begin
    div_busy  = (state_q != S_IDLE);
    div_out   = (state_q == S_DONE) & ~mul_exit_v;
    last_iter = (state_q == S_RUN) & (cnt_q == CW'(XLEN - 1));
  end

  // Divider datapath: load on issue, iterate in RUN, sign-fix on the last step
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (div_issue) begin
        rem_q      <= '0;
        quo_q      <= lhs_mag;
        dvs_q      <= rhs_mag;
        cnt_q      <= '0;
        neg_quo_q  <= lhs_neg ^ rhs_neg;
        neg_rem_q  <= lhs_neg;
        want_rem_q <= opcode[1];
        dtag_q     <= tag;
        dres_q     <= special_res;
      end else if (state_q == S_RUN) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q + CW'(1);
        if (last_iter) begin
          dres_q <= want_rem_q ? rem_fix : quo_fix;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Result broadcast: mul exit first, then a finished divide
  // ---------------------------------------------------------------------
  // Registered result port; value and tag hold between pulses
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      done_result  <= 1'b0;
      value_result <= '0;
      tag_result   <= '0;
    end else if (rdy_in) begin
      if (clear_signal) begin
        done_result <= 1'b0;
      end else if (mul_exit_v) begin
        done_result  <= 1'b1;
        value_result <= mul_exit_val;
        tag_result   <= mul_exit_tag;
      end else if (div_out) begin
        done_result  <= 1'b1;
        value_result <= dres_q;
        tag_result   <= dtag_q;
      end else begin
        done_result <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against a result-schedule model
`timescale 1ns/1ps

module tb_muldiv_unit;

  localparam int XLEN       = 32;
  localparam int RW         = 4;
  localparam int MUL_STAGES = 2;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            rdy_in;
  logic            clear_signal;
  logic            cal_signal;
  logic [2:0]      opcode;
  logic [XLEN-1:0] lhs;
  logic [XLEN-1:0] rhs;
  logic [RW-1:0]   tag;
  logic            div_busy;
  logic            done_result;
  logic [XLEN-1:0] value_result;
  logic [RW-1:0]   tag_result;

  always #5 clk_in = ~clk_in;

  muldiv_unit #(.ROB_WIDTH(RW), .XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear_signal (clear_signal),
    .cal_signal   (cal_signal),
    .opcode       (opcode),
    .lhs          (lhs),
    .rhs          (rhs),
    .tag          (tag),
    .div_busy     (div_busy),
    .done_result  (done_result),
    .value_result (value_result),
    .tag_result   (tag_result)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int              due;
    logic [RW-1:0]   tag;
    logic [XLEN-1:0] val;
  } res_t;

  res_t            mulq[$];
  bit              div_pend = 0;
  int              div_t    = 0;
  int              div_due  = 0;
  logic [XLEN-1:0] div_val;
  logic [RW-1:0]   div_tag;
  logic            exp_done;
  logic [XLEN-1:0] exp_val;
  logic [RW-1:0]   exp_tag;
  logic            exp_busy = 1'b0;

  logic            p_rst, p_rdy, p_clr, p_cal;
  logic [2:0]      p_op;
  logic [XLEN-1:0] p_a, p_b;
  logic [RW-1:0]   p_tag;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, ub;
    logic [31:0] q, r;
    logic        sgn;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'h0, b});
    p   = '0;
    q   = '0;
    r   = '0;
    sgn = ~op[0];
    case (op)
      3'd0: p = {32'h0, a} * {32'h0, b};
      3'd1: p = sa * sb;
      3'd2: p = sa * ub;
      3'd3: p = {32'h0, a} * {32'h0, b};
      default: begin
        if (b == 32'h0) begin
          q = '1;
          r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = a;
          r = 32'h0;
        end else if (sgn) begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
        end else begin
          q = a / b;
          r = a % b;
        end
      end
    endcase
    if (!op[2]) return (op == 3'd0) ? p[31:0] : p[63:32];
    return op[1] ? r : q;
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Advance one clock, update the expected-result schedule and compare every output.
  task automatic step();
    res_t r;
    logic prev_busy;
    p_rst = rst_in; p_rdy = rdy_in; p_clr = clear_signal; p_cal = cal_signal;
    p_op  = opcode; p_a = lhs; p_b = rhs; p_tag = tag;
    @(posedge clk_in);
    cyc++;
    #1;
    prev_busy = exp_busy;
    if (!p_rst) begin
      mulq.delete();
      div_pend = 0;
      exp_done = 1'b0; exp_val = '0; exp_tag = '0; exp_busy = 1'b0;
    end else if (!p_rdy) begin
      foreach (mulq[i]) mulq[i].due++;
      div_t++;
      div_due++;
    end else if (p_clr) begin
      mulq.delete();
      div_pend = 0;
      exp_done = 1'b0;
      exp_busy = 1'b0;
    end else begin
      if (div_pend && div_due == cyc && mulq.size() > 0 && mulq[0].due == cyc) div_due++;
      exp_done = 1'b0;
      if (mulq.size() > 0 && mulq[0].due == cyc) begin
        r = mulq.pop_front();
        exp_done = 1'b1; exp_val = r.val; exp_tag = r.tag;
      end else if (div_pend && div_due == cyc) begin
        exp_done = 1'b1; exp_val = div_val; exp_tag = div_tag;
        div_pend = 0;
      end
      if (p_cal) begin
        if (!p_op[2]) begin
          r.due = cyc - 1 + MUL_STAGES;
          r.tag = p_tag;
          r.val = ref_result(p_op, p_a, p_b);
          mulq.push_back(r);
        end else if (!prev_busy) begin
          div_pend = 1;
          div_t    = cyc - 1;
          div_due  = is_special(p_op, p_a, p_b) ? (cyc + 1) : (cyc + XLEN + 1);
          div_val  = ref_result(p_op, p_a, p_b);
          div_tag  = p_tag;
        end
      end
      exp_busy = div_pend && cyc > div_t && cyc < div_due;
    end
    check("done",  {31'b0, done_result}, {31'b0, exp_done});
    check("value", value_result, exp_val);
    check("tag",   {28'b0, tag_result}, {28'b0, exp_tag});
    check("busy",  {31'b0, div_busy}, {31'b0, exp_busy});
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [RW-1:0] t);
    cal_signal = 1'b1; opcode = op; lhs = a; rhs = b; tag = t;
    step();
    cal_signal = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int t0;
    logic [2:0] op;
    rst_in = 1'b0; rdy_in = 1'b1; clear_signal = 1'b0; cal_signal = 1'b0;
    opcode = '0; lhs = '0; rhs = '0; tag = '0;
    step();
    step();
    check("reset_done", {31'b0, done_result}, 32'h0);
    check("reset_val", value_result, 32'h0);
    rst_in = 1'b1;
    step();

    // MUL 7 * -3
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 4'd5);
    step();
    check("mul_done", {31'b0, done_result}, 32'h1);
    check("mul_val", value_result, 32'hFFFF_FFEB);
    check("mul_tag", {28'b0, tag_result}, 32'd5);

    // back-to-back MULH / MULHU / MULHSU
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 4'd1);
    issue(3'd3, 32'h8000_0000, 32'h8000_0000, 4'd2);
    check("mulh_val", value_result, 32'h4000_0000);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3);
    check("mulhu_val", value_result, 32'h4000_0000);
    step();
    check("mulhsu_val", value_result, 32'hFFFF_FFFF);
    check("mulhsu_tag", {28'b0, tag_result}, 32'd3);
    step();

    // DIV -7/2 latency and value
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 4'd6);
    repeat (32) step();
    check("div_early", {31'b0, done_result}, 32'h0);
    step();
    check("div_done", {31'b0, done_result}, 32'h1);
    check("div_val", value_result, 32'hFFFF_FFFD);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 4'd7);
    repeat (33) step();
    check("rem_val", value_result, 32'hFFFF_FFFF);
    issue(3'd5, 32'd100, 32'd7, 4'd4);
    repeat (33) step();
    check("divu_val", value_result, 32'd14);

    // special cases: one busy cycle, result at T+2
    issue(3'd4, 32'd5, 32'd0, 4'd8);
    check("sp0_busy", {31'b0, div_busy}, 32'h1);
    step();
    check("sp0_val", value_result, 32'hFFFF_FFFF);
    check("sp0_busy_after", {31'b0, div_busy}, 32'h0);
    issue(3'd7, 32'd5, 32'd0, 4'd9);
    step();
    check("sp1_val", value_result, 32'd5);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd10);
    step();
    check("sp2_val", value_result, 32'h8000_0000);
    step();

    // contention: mul and div finish in the same cycle
    issue(3'd4, 32'd1000, 32'd3, 4'd9);
    repeat (31) step();
    issue(3'd0, 32'd2, 32'd3, 4'd10);
    step();
    check("cont_mul_tag", {28'b0, tag_result}, 32'd10);
    check("cont_mul_val", value_result, 32'd6);
    step();
    check("cont_div_done", {31'b0, done_result}, 32'h1);
    check("cont_div_tag", {28'b0, tag_result}, 32'd9);
    check("cont_div_val", value_result, 32'd333);

    // flush mid-RUN, then a div right after
    issue(3'd5, 32'd12345, 32'd7, 4'd11);
    repeat (9) step();
    clear_signal = 1'b1; cal_signal = 1'b1; opcode = 3'd0; lhs = 32'd3; rhs = 32'd3; tag = 4'd14;
    step();
    clear_signal = 1'b0; cal_signal = 1'b0;
    check("clr_busy", {31'b0, div_busy}, 32'h0);
    issue(3'd4, 32'd50, 32'hFFFF_FFFB, 4'd12);
    repeat (33) step();
    check("postclr_val", value_result, 32'hFFFF_FFF6);
    check("postclr_tag", {28'b0, tag_result}, 32'd12);
    repeat (10) step();

    // pause 5 cycles mid-RUN
    t0 = cyc;
    issue(3'd7, 32'd1000, 32'd7, 4'd13);
    repeat (9) step();
    rdy_in = 1'b0; cal_signal = 1'b1; opcode = 3'd0; tag = 4'd15;
    repeat (5) step();
    rdy_in = 1'b1; cal_signal = 1'b0;
    for (int k = 0; k < 60 && cyc < t0 + 38; k++) step();
    check("pause_early", {31'b0, done_result}, 32'h0);
    step();
    check("pause_done", {31'b0, done_result}, 32'h1);
    check("pause_val", value_result, 32'd6);

    // reset mid-RUN
    issue(3'd4, 32'd77, 32'd5, 4'd3);
    repeat (5) step();
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    check("rstmid_val", value_result, 32'h0);
    check("rstmid_tag", {28'b0, tag_result}, 32'h0);
    check("rstmid_busy", {31'b0, div_busy}, 32'h0);
    repeat (40) step();

    // randomized traffic with pauses and flushes
    for (int n = 0; n < 3000; n++) begin
      rdy_in       = ($urandom % 8) != 0;
      clear_signal = ($urandom % 64) == 0;
      cal_signal   = $urandom % 2;
      op           = $urandom % 8;
      if (exp_busy) op[2] = 1'b0;
      opcode = op;
      lhs    = pick();
      rhs    = pick();
      tag    = $urandom;
      step();
    end
    rdy_in = 1'b1; clear_signal = 1'b0; cal_signal = 1'b0;
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
